// File: rtl/audio_buffer_player_pkg.sv
// rtl/audio_buffer_player_pkg.sv - shared FSM states and buffer constants for audio_buffer_player
package audio_buffer_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STAGED,
    ST_RELEASE
  } state_t;

  localparam int         MARKER_BIT               = 8;
  localparam logic [7:0] CH_MONO                  = 8'd1;
  localparam logic [7:0] CH_STEREO                = 8'd2;
  localparam int         BUFFER_ADDR_BITS_DEFAULT = 10;

  function automatic logic [2:0] frame_bytes(input logic stereo);
    return stereo ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/audio_buffer_player_pwm_dac.sv
// rtl/audio_buffer_player_pwm_dac.sv - free-running counter PWM of the sample MSBs in offset binary
module pwm_dac #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] sample_msbs,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;

  // Flipping the sign bit maps signed -full..+full onto 0..2^PWM_BITS-1.
  assign duty = {~sample_msbs[PWM_BITS-1], sample_msbs[PWM_BITS-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/audio_buffer_player.sv
// rtl/audio_buffer_player.sv - drains one PCM buffer at the WAV rate; AUDIO_PLAYER_UNDERRUN_CNT_EN adds underrun_count_o
module audio_buffer_player
  import audio_buffer_player_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50000000,
  parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEFAULT,
  parameter int PWM_BITS         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        play_en_i,
  input  logic [31:0]                 wav_info_sampling_rate_i,
  input  logic [7:0]                  wav_info_audio_channels_i,
  input  logic                        audio_buffer_filled_i,
  output logic                        audio_buffer_empty_o,
  output logic [BUFFER_ADDR_BITS-1:0] audio_buffer_addr_o,
  output logic                        audio_buffer_rden_o,
  input  logic [8:0]                  audio_buffer_data_i,
  output logic [15:0]                 sample_l_o,
  output logic [15:0]                 sample_r_o,
  output logic                        sample_strobe_o,
  output logic                        underrun_o,
  output logic                        pwm_l_o,
  output logic                        pwm_r_o
`ifdef AUDIO_PLAYER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_count_o
`endif
);

  state_t      state, state_next;
  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic        tick;
  logic        stereo;
  logic [2:0]  fb;
  logic [2:0]  issue_cnt;
  logic [1:0]  recv_cnt;
  logic        rd_pending;
  logic [31:0] stage;
  logic        marker;
  logic        start;

  // Fractional rate divider: one tick per CLK_FREQ_HZ/rate cycles on average.
  assign acc_sum = {1'b0, acc} + {1'b0, wav_info_sampling_rate_i};
  assign tick    = (acc_sum >= 33'(CLK_FREQ_HZ));
  assign fb      = frame_bytes(stereo);
  assign marker  = audio_buffer_data_i[MARKER_BIT];
  assign start   = audio_buffer_filled_i && play_en_i &&
                   (wav_info_audio_channels_i == CH_MONO || wav_info_audio_channels_i == CH_STEREO);
  assign audio_buffer_empty_o = (state == ST_RELEASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next          = state;
    audio_buffer_rden_o = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        audio_buffer_rden_o = (issue_cnt < fb);
        if (rd_pending) begin
          if (marker)                               state_next = ST_RELEASE;
          else if ({1'b0, recv_cnt} == fb - 3'd1)  state_next = ST_STAGED;
        end
      end
      ST_STAGED: if (tick) state_next = (audio_buffer_addr_o == '0) ? ST_RELEASE : ST_FETCH;
      ST_RELEASE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc                 <= '0;
      stereo              <= 1'b0;
      issue_cnt           <= '0;
      recv_cnt            <= '0;
      rd_pending          <= 1'b0;
      stage               <= '0;
      audio_buffer_addr_o <= '0;
      sample_l_o          <= '0;
      sample_r_o          <= '0;
      sample_strobe_o     <= 1'b0;
      underrun_o          <= 1'b0;
    end else begin
      acc             <= tick ? 32'(acc_sum - 33'(CLK_FREQ_HZ)) : acc_sum[31:0];
      rd_pending      <= audio_buffer_rden_o;
      sample_strobe_o <= 1'b0;
      underrun_o      <= tick && (state != ST_STAGED);
      if (audio_buffer_rden_o) begin
        audio_buffer_addr_o <= audio_buffer_addr_o + BUFFER_ADDR_BITS'(1);
        issue_cnt           <= issue_cnt + 3'd1;
      end
      case (state)
        ST_IDLE: begin
          audio_buffer_addr_o <= '0;
          issue_cnt           <= '0;
          recv_cnt            <= '0;
          if (start) stereo <= (wav_info_audio_channels_i == CH_STEREO);
        end
        ST_FETCH: begin
          if (rd_pending && !marker) begin
            stage[{recv_cnt, 3'b000} +: 8] <= audio_buffer_data_i[7:0];
            recv_cnt                       <= recv_cnt + 2'd1;
          end
        end
        ST_STAGED: begin
          if (tick) begin
            sample_l_o      <= stage[15:0];
            sample_r_o      <= stereo ? stage[31:16] : stage[15:0];
            sample_strobe_o <= 1'b1;
            issue_cnt       <= '0;
            recv_cnt        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AUDIO_PLAYER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  underrun_cnt <= '0;
    else if (underrun_o && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end

  assign underrun_count_o = underrun_cnt;
`endif

  pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm_l (
    .clk         (clk),
    .rst         (rst),
    .sample_msbs (sample_l_o[15 -: PWM_BITS]),
    .pwm         (pwm_l_o)
  );

  pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk         (clk),
    .rst         (rst),
    .sample_msbs (sample_r_o[15 -: PWM_BITS]),
    .pwm         (pwm_r_o)
  );

endmodule

// File: doc/audio_buffer_player.md
Name: audio_buffer_player

Overview:
- Downstream consumer of the audio buffer filled by the FAT32 WAV reader.
- Drains one buffer of 16-bit little-endian signed PCM at the WAV sampling rate and presents left/right samples plus PWM outputs to the DAC/output filter.
- Returns the buffer to the writer via the empty handshake.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency used by the sample-tick accumulator.
- BUFFER_ADDR_BITS, 10, byte-address width of the audio buffer; buffer size 2^BUFFER_ADDR_BITS, must be a multiple of 4.
- PWM_BITS, 8, resolution of the PWM outputs, taken from the sample MSBs.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- play_en_i  in  1  level; when low, no new buffer is started.
- wav_info_sampling_rate_i  in  32  samples/s from the WAV header.
- wav_info_audio_channels_i  in  8  1 = mono, 2 = stereo.
- audio_buffer_filled_i  in  1  level; buffer holds valid data.
- audio_buffer_empty_o  out  1  one-cycle pulse; buffer fully consumed.
- audio_buffer_addr_o  out  BUFFER_ADDR_BITS  RAM read byte address.
- audio_buffer_rden_o  out  1  RAM read enable; data valid on audio_buffer_data_i one cycle later.
- audio_buffer_data_i  in  9  [7:0] byte, [8] end-of-data marker.
- sample_l_o  out  16  signed left sample.
- sample_r_o  out  16  signed right sample.
- sample_strobe_o  out  1  one-cycle pulse when samples update.
- underrun_o  out  1  one-cycle pulse when a tick finds no staged frame.
- pwm_l_o  out  1  left PWM output.
- pwm_r_o  out  1  right PWM output.

Behaviour:
- Reset values: all outputs 0; accumulator 0; state IDLE; address 0.
- Sample tick:
  - 32-bit accumulator; each cycle acc += rate.
  - If acc + rate >= CLK_FREQ_HZ: acc <= acc + rate - CLK_FREQ_HZ and tick for 1 cycle.
  - rate = 0 gives no ticks.
  - Runs in every state.
- IDLE:
  - Go to FETCH when filled_i && play_en_i && channels ∈ {1,2}.
  - Channel count is latched at this transition and ignored mid-buffer.
  - Address resets to 0.
- FETCH:
  - Issue rden with an incrementing address.
  - Collect 2 bytes (mono) or 4 bytes (stereo) into staging registers: L lo, L hi, R lo, R hi.
  - Mono: R = L.
  - Go to STAGED after the last byte returns.
- STAGED, on tick:
  - Commit staging to sample_l_o/sample_r_o and pulse sample_strobe_o in the same cycle.
  - If the address wrapped to 0 (whole buffer read), go to RELEASE; else go to FETCH.
- Tick while in IDLE/FETCH/RELEASE: pulse underrun_o; samples hold their previous values.
- Marker byte (data[8] = 1):
  - The byte is discarded, along with any partial frame.
  - Go to RELEASE; previously committed samples stand.
- RELEASE: pulse audio_buffer_empty_o for 1 cycle, then go to IDLE. IDLE waits for the writer to raise filled_i again.
- Simultaneous tick and RELEASE→IDLE: underrun is counted; no other effect.
- play_en_i low mid-buffer: the current buffer is finished normally; no new buffer starts.
- Async rst mid-operation: return to reset values immediately; no empty pulse is issued.
- PWM:
  - Sub-module driven by a free-running PWM_BITS counter.
  - Duty = {~s[15], s[14:16-PWM_BITS]}, i.e. offset-binary MSBs.
  - Output high while counter < duty.
- Latency:
  - Filled to first rden: 1 cycle.
  - Byte read: 1 cycle.
  - Frame staged: 3 cycles (mono) or 5 cycles (stereo) after FETCH entry.

Optional Feature:
- Macro: AUDIO_PLAYER_UNDERRUN_CNT_EN.
- Defined: extra output underrun_count_o[15:0], a saturating count of underrun_o pulses, cleared by rst only.
- Undefined: port absent; underrun_o pulse only.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE, FETCH, STAGED, RELEASE).
  - Marker bit index (8).
  - Channel constants (MONO = 1, STEREO = 2).
  - BUFFER_ADDR_BITS default, shared with the buffer constants.
- One sub-module: pwm_dac (counter + compare), instantiated twice for L and R.

Test Plan:
- Mono 44100 Hz, CLK_FREQ_HZ = 441000 (scaled): buffer bytes 0x34,0x12,… → first strobe yields sample_l_o = sample_r_o = 0x1234; strobes exactly every 10 cycles.
- Stereo, bytes 01 00 FF 7F → L = 0x0001, R = 0x7FFF. After 2^BUFFER_ADDR_BITS bytes, exactly one audio_buffer_empty_o pulse.
- Marker byte at address 6 in stereo → frame 1 discarded, empty_o pulses, return to IDLE, samples hold the frame-0 values.
- filled_i low while ticks run → underrun_o pulses every tick; with AUDIO_PLAYER_UNDERRUN_CNT_EN, count saturates at 0xFFFF.
- Channels = 3, or play_en_i = 0, with filled_i = 1 → stays in IDLE with no rden.
- rst pulsed mid-FETCH → all outputs 0 immediately; no empty pulse; restarts at address 0 on the next filled_i.
- PWM_BITS = 8, sample 0x0000 → pwm_l_o duty 128/256; sample 0x8000 → duty 0.
